id_ex_stage: RTL and testbench

//  ID/EX pipeline register, downstream of the register file: captures decode-stage

---
 rtl/id_ex_stage.sv | 134 +++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register.
// Captures decode operands/controls, applies WB->ID bypass, detects load-use
// hazards against the instruction currently in EX, inserts bubbles on flush
// or hazard, freezes on hold, and keeps a saturating count of stall cycles.
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_uses_rt,
    input  logic [DW-1:0]    id_data1,
    input  logic [DW-1:0]    id_data2,
    input  logic [DW-1:0]    id_imm,
    input  logic [8:0]       id_ctrl,
    input  logic             wb_reg_write,
    input  logic [AW-1:0]    wb_write_reg,
    input  logic [DW-1:0]    wb_write_data,
    output logic             stall,
    output logic             ex_valid,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_rd,
    output logic [DW-1:0]    ex_data1,
    output logic [DW-1:0]    ex_data2,
    output logic [DW-1:0]    ex_imm,
    output logic [8:0]       ex_ctrl,
    output logic [CNT_W-1:0] stall_count
);

    // Control word packing: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,alu_op[2:0]}
    localparam int MEM_READ_BIT = 7;

    // EX-side state
    logic             r_ex_valid;
    logic [AW-1:0]    r_ex_rs;
    logic [AW-1:0]    r_ex_rt;
    logic [AW-1:0]    r_ex_rd;
    logic [DW-1:0]    r_ex_data1;
    logic [DW-1:0]    r_ex_data2;
    logic [DW-1:0]    r_ex_imm;
    logic [8:0]       r_ex_ctrl;
    logic [CNT_W-1:0] r_stall_count;

    // Hazard / stall decode
    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_stall;

    // Bypassed operands, one lane per source register
    logic [AW-1:0] w_src_addr [2];
    logic [DW-1:0] w_src_data [2];
    logic [DW-1:0] w_byp_data [2];
    logic          w_wb_live;

    assign w_src_addr[0] = id_rs;
    assign w_src_addr[1] = id_rt;
    assign w_src_data[0] = id_data1;
    assign w_src_data[1] = id_data2;

    // A write to register 0 is architecturally discarded, so never forward it.
    assign w_wb_live = wb_reg_write && (wb_write_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign w_byp_data[gi] = (w_wb_live && (wb_write_reg == w_src_addr[gi]))
                                    ? wb_write_data : w_src_data[gi];
        end
    endgenerate

    // A load in EX targeting a nonzero register that ID reads must wait one cycle.
    assign w_ex_is_load = r_ex_valid && r_ex_ctrl[MEM_READ_BIT] && (r_ex_rt != '0);
    assign w_rs_match   = (r_ex_rt == id_rs);
    assign w_rt_match   = id_uses_rt && (r_ex_rt == id_rt);
    assign w_hazard     = id_valid && w_ex_is_load && (w_rs_match || w_rt_match);

    // Flush already kills the ID instruction and hold already freezes the front
    // end, so neither needs an extra stall.
    assign w_stall = w_hazard && !flush && !hold;

    // EX register update: reset > flush > hold > hazard bubble > load
    always_ff @(posedge clk) begin
        if (rst || flush || (!hold && w_hazard)) begin
            r_ex_valid <= 1'b0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_rd    <= '0;
            r_ex_data1 <= '0;
            r_ex_data2 <= '0;
            r_ex_imm   <= '0;
            r_ex_ctrl  <= '0;
        end else if (!hold) begin
            r_ex_valid <= id_valid;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_ex_rd    <= id_rd;
            r_ex_data1 <= w_byp_data[0];
            r_ex_data2 <= w_byp_data[1];
            r_ex_imm   <= id_imm;
            r_ex_ctrl  <= id_valid ? id_ctrl : 9'd0;
        end
    end

    // Saturating stall-cycle counter; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign ex_valid    = r_ex_valid;
    assign ex_rs       = r_ex_rs;
    assign ex_rt       = r_ex_rt;
    assign ex_rd       = r_ex_rd;
    assign ex_data1    = r_ex_data1;
    assign ex_data2    = r_ex_data2;
    assign ex_imm      = r_ex_imm;
    assign ex_ctrl     = r_ex_ctrl;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage.
// A default-width instance and a CNT_W=4 instance share the same stimulus.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, hold, id_valid, id_uses_rt, wb_reg_write;
    logic [AW-1:0] id_rs, id_rt, id_rd, wb_write_reg;
    logic [DW-1:0] id_data1, id_data2, id_imm, wb_write_data;
    logic [8:0]    id_ctrl;

    logic          stall, ex_valid;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_data1, ex_data2, ex_imm;
    logic [8:0]    ex_ctrl;
    logic [15:0]   stall_count;

    logic          s4_stall, s4_valid;
    logic [AW-1:0] s4_rs, s4_rt, s4_rd;
    logic [DW-1:0] s4_d1, s4_d2, s4_imm;
    logic [8:0]    s4_ctrl;
    logic [3:0]    s4_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .stall(s4_stall), .ex_valid(s4_valid), .ex_rs(s4_rs), .ex_rt(s4_rt), .ex_rd(s4_rd),
        .ex_data1(s4_d1), .ex_data2(s4_d2), .ex_imm(s4_imm), .ex_ctrl(s4_ctrl),
        .stall_count(s4_count)
    );

    typedef struct {
        logic          valid;
        logic [AW-1:0] rs, rt, rd;
        logic [DW-1:0] d1, d2, imm;
        logic [8:0]    ctrl;
        logic [15:0]   cnt;
        logic [3:0]    cnt4;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    bit   m_known = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; hold = 0; id_valid = 0; id_uses_rt = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_data1 = 0; id_data2 = 0; id_imm = 0;
        id_ctrl = 0; wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
    endtask

    task automatic instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic urt, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                         input logic [8:0] ctrl);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_data1 = d1; id_data2 = d2; id_imm = d1 ^ 32'h0000_F00F; id_ctrl = ctrl;
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic cycle(input string tag);
        exp_t n;
        logic hz, st;
        logic [DW-1:0] b1, b2;
        #2;
        hz = id_valid && m.valid && m.ctrl[7] && (m.rt != 0) &&
             ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
        st = hz && !flush && !hold;
        if (m_known) chk({tag, ".stall"}, stall, st);
        b1 = (wb_reg_write && wb_write_reg != 0 && wb_write_reg == id_rs) ? wb_write_data : id_data1;
        b2 = (wb_reg_write && wb_write_reg != 0 && wb_write_reg == id_rt) ? wb_write_data : id_data2;
        n = m;
        if (rst) begin
            n = '{default: '0};
        end else begin
            if (flush || (!hold && hz)) begin
                n.valid = 0; n.rs = 0; n.rt = 0; n.rd = 0;
                n.d1 = 0; n.d2 = 0; n.imm = 0; n.ctrl = 0;
            end else if (!hold) begin
                n.valid = id_valid; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
                n.d1 = b1; n.d2 = b2; n.imm = id_imm; n.ctrl = id_valid ? id_ctrl : 9'd0;
            end
            if (st && n.cnt != 16'hFFFF) n.cnt = n.cnt + 1;
            if (st && n.cnt4 != 4'hF) n.cnt4 = n.cnt4 + 1;
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
        n = sb.pop_front();
        if (rst) m_known = 1;
        if (m_known) begin
            chk({tag, ".valid"}, ex_valid, n.valid);
            chk({tag, ".rs"}, ex_rs, n.rs);
            chk({tag, ".rt"}, ex_rt, n.rt);
            chk({tag, ".rd"}, ex_rd, n.rd);
            chk({tag, ".data1"}, ex_data1, n.d1);
            chk({tag, ".data2"}, ex_data2, n.d2);
            chk({tag, ".imm"}, ex_imm, n.imm);
            chk({tag, ".ctrl"}, ex_ctrl, n.ctrl);
            chk({tag, ".count"}, stall_count, n.cnt);
            chk({tag, ".count4"}, s4_count, n.cnt4);
        end
        $display("cycle %s: rst=%0b flush=%0b hold=%0b stall=%0b ex_valid=%0b ex_ctrl=%03h d1=%08h d2=%08h cnt=%0d cnt4=%0d",
                 tag, rst, flush, hold, st, ex_valid, ex_ctrl, ex_data1, ex_data2, stall_count, s4_count);
        m = n;
    endtask

    localparam logic [8:0] C_LW  = 9'h1B0;  // reg_write, mem_read, mem_to_reg, alu_src
    localparam logic [8:0] C_ADD = 9'h10A;  // reg_write, reg_dst, alu_op=2

    initial begin
        m = '{default: '0};
        idle();
        rst = 1;
        @(posedge clk); #1;

        // Reset held for two cycles
        cycle("rst0");
        cycle("rst1");
        rst = 0;
        #1;
        chk("reset.ex_valid", ex_valid, 0);
        chk("reset.ex_ctrl", ex_ctrl, 0);
        chk("reset.ex_data1", ex_data1, 0);
        chk("reset.count", stall_count, 0);
        cycle("idle");

        // Plain load
        instr(5'd3, 5'd0, 5'd4, 1'b0, 32'h11, 32'h0, 9'h1C0);
        cycle("load");
        chk("load.ex_data1", ex_data1, 32'h11);
        chk("load.ex_ctrl", ex_ctrl, 9'h1C0);
        chk("load.ex_valid", ex_valid, 1);

        // Load-use: lw rt=5 then add rs=5
        instr(5'd1, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, C_LW);
        cycle("lw");
        instr(5'd5, 5'd6, 5'd8, 1'b1, 32'h33, 32'h44, C_ADD);
        #1;
        chk("luse.stall", stall, 1);
        cycle("luse_bubble");
        chk("luse.bubble_valid", ex_valid, 0);
        chk("luse.bubble_ctrl", ex_ctrl, 0);
        chk("luse.count", stall_count, 1);
        #1;
        chk("luse.stall_gone", stall, 0);
        cycle("luse_add");
        chk("luse.add_ctrl", ex_ctrl, C_ADD);
        chk("luse.add_data1", ex_data1, 32'h33);

        // WB bypass on rt, then on register 0, then on rs
        instr(5'd0, 5'd7, 5'd9, 1'b1, 32'h55, 32'h0, C_ADD);
        wb_reg_write = 1; wb_write_reg = 5'd7; wb_write_data = 32'hDEAD;
        cycle("byp_rt");
        chk("byp.data2", ex_data2, 32'hDEAD);
        id_rt = 5'd0; wb_write_reg = 5'd0;
        cycle("byp_r0");
        chk("byp.r0_data2", ex_data2, 32'h0);
        chk("byp.r0_data1", ex_data1, 32'h55);
        id_rs = 5'd9; id_data1 = 32'h1; wb_write_reg = 5'd9; wb_write_data = 32'hBEEF;
        cycle("byp_rs");
        chk("byp.data1", ex_data1, 32'hBEEF);
        wb_reg_write = 0;

        // Flush during hazard
        instr(5'd2, 5'd5, 5'd0, 1'b0, 32'h7, 32'h0, C_LW);
        cycle("lw2");
        instr(5'd0, 5'd5, 5'd3, 1'b1, 32'h9, 32'h8, C_ADD);
        flush = 1;
        #1;
        chk("flush.stall", stall, 0);
        cycle("flush");
        chk("flush.valid", ex_valid, 0);
        chk("flush.ctrl", ex_ctrl, 0);
        chk("flush.data2", ex_data2, 0);
        flush = 0;

        // Hold with a pending hazard: frozen for 3 cycles, then hazard re-evaluates
        instr(5'd2, 5'd5, 5'd0, 1'b0, 32'hA5A5, 32'h0, C_LW);
        cycle("lw3");
        instr(5'd5, 5'd1, 5'd6, 1'b0, 32'h1234, 32'h0, C_ADD);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold.stall", stall, 0);
            cycle("hold");
            chk("hold.data1", ex_data1, 32'hA5A5);
            chk("hold.ctrl", ex_ctrl, C_LW);
        end
        hold = 0;
        #1;
        chk("hold.release_stall", stall, 1);
        cycle("hold_release");
        cycle("hold_add");

        // Counter saturation on the CNT_W=4 instance
        for (int i = 0; i < 18; i++) begin
            instr(5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, C_LW);
            cycle("sat_lw");
            instr(5'd5, 5'd0, 5'd2, 1'b0, 32'h0, 32'h0, C_ADD);
            cycle("sat_use");
        end
        chk("sat.count4", s4_count, 4'hF);
        chk("sat.count16", stall_count, 16'd20);

        // Reset in the middle of a stall
        instr(5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, C_LW);
        cycle("mid_lw");
        instr(5'd5, 5'd0, 5'd2, 1'b0, 32'h0, 32'h0, C_ADD);
        rst = 1;
        cycle("mid_rst");
        rst = 0;
        #1;
        chk("midrst.stall", stall, 0);
        chk("midrst.count", stall_count, 0);
        chk("midrst.count4", s4_count, 0);
        cycle("mid_after");

        chk("scoreboard.empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
